// File: rtl/flexbex_efpga_pkg.sv
// Shared types and constants for the eFPGA custom-instruction bridge.
package flexbex_efpga_pkg;

    localparam int unsigned DELAY_W = 4;
    localparam logic [31:0] ERR_RESULT_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        EFPGA_IDLE = 2'd0,
        EFPGA_RUN  = 2'd1,
        EFPGA_HOLD = 2'd2
    } efpga_state_e;

    typedef logic [1:0] efpga_op_t;

    localparam efpga_op_t EFPGA_OP_CUSTOM0 = 2'd0;
    localparam efpga_op_t EFPGA_OP_CUSTOM1 = 2'd1;
    localparam efpga_op_t EFPGA_OP_CUSTOM2 = 2'd2;
    localparam efpga_op_t EFPGA_OP_CUSTOM3 = 2'd3;

    // A zero latency means the fabric signals completion itself.
    function automatic logic is_handshake(input logic [DELAY_W-1:0] delay);
        return delay == '0;
    endfunction

endpackage

// File: rtl/flexbex_efpga_latency_counter.sv
// Saturating cycle counter with fixed-latency and timeout terminal compares.
module flexbex_efpga_latency_counter
    import flexbex_efpga_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               run_i,
    input  logic [DELAY_W-1:0] delay_i,
    output logic               first_cycle_o,
    output logic               delay_hit_o,
    output logic               timeout_o
);

    localparam int unsigned CMP_W = (TIMEOUT_W > DELAY_W) ? TIMEOUT_W : DELAY_W;
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] count_d;
    logic [TIMEOUT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i && (count_q != CNT_MAX)) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign first_cycle_o = (count_q == '0);
    assign delay_hit_o   = !is_handshake(delay_i) && (CMP_W'(count_q) == CMP_W'(delay_i));
    assign timeout_o     = (count_q == CNT_MAX);

endmodule

// File: rtl/flexbex_efpga_bridge.sv
// Bridge between the core's eFPGA custom-instruction port and the fabric:
// launches, waits for fixed latency or handshake, returns registered results.
//
// state | meaning
// IDLE  | no operation; waits for enable + write strobe
// RUN   | fabric launched; waiting for latency, done handshake, timeout or abort
// HOLD  | results valid (core_done_o high) until the core drops enable
module flexbex_efpga_bridge
    import flexbex_efpga_pkg::*;
#(
    parameter int unsigned TIMEOUT_W  = 8,
    parameter logic [31:0] ERR_RESULT = ERR_RESULT_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_en_i,
    input  logic               core_write_strobe_i,
    input  logic [1:0]         core_operator_i,
    input  logic [DELAY_W-1:0] core_delay_i,
    input  logic [31:0]        core_operand_a_i,
    input  logic [31:0]        core_operand_b_i,
    output logic [31:0]        core_result_a_o,
    output logic [31:0]        core_result_b_o,
    output logic [31:0]        core_result_c_o,
    output logic               core_done_o,
    output logic               core_err_o,
    output logic               busy_o,
    output logic [31:0]        fabric_operand_a_o,
    output logic [31:0]        fabric_operand_b_o,
    output logic [1:0]         fabric_operator_o,
    output logic               fabric_start_o,
    output logic               fabric_abort_o,
    input  logic [31:0]        fabric_result_a_i,
    input  logic [31:0]        fabric_result_b_i,
    input  logic [31:0]        fabric_result_c_i,
    input  logic               fabric_done_i
);

    localparam logic [1:0] IDLE = EFPGA_IDLE;
    localparam logic [1:0] RUN  = EFPGA_RUN;
    localparam logic [1:0] HOLD = EFPGA_HOLD;

    logic [1:0]         state_d,    state_q;
    logic [DELAY_W-1:0] delay_d,    delay_q;
    logic [31:0]        op_a_d,     op_a_q;
    logic [31:0]        op_b_d,     op_b_q;
    efpga_op_t          operator_d, operator_q;
    logic [31:0]        res_a_d,    res_a_q;
    logic [31:0]        res_b_d,    res_b_q;
    logic [31:0]        res_c_d,    res_c_q;
    logic               done_d,     done_q;
    logic               err_d,      err_q;
    logic               start_d,    start_q;
    logic               abort_d,    abort_q;

    logic launch;
    logic running;
    logic first_cycle;
    logic delay_hit;
    logic timeout;
    logic complete;

    assign running = (state_q == RUN);

    flexbex_efpga_latency_counter #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_latency_counter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (launch),
        .run_i         (running),
        .delay_i       (delay_q),
        .first_cycle_o (first_cycle),
        .delay_hit_o   (delay_hit),
        .timeout_o     (timeout)
    );

    // A done seen in the launch cycle belongs to a previous fabric op, not this one.
    assign complete = is_handshake(delay_q) ? (fabric_done_i && !first_cycle) : delay_hit;

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        operator_d = operator_q;
        res_a_d    = res_a_q;
        res_b_d    = res_b_q;
        res_c_d    = res_c_q;
        done_d     = done_q;
        err_d      = err_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        launch     = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_en_i && core_write_strobe_i) begin
                    launch     = 1'b1;
                    op_a_d     = core_operand_a_i;
                    op_b_d     = core_operand_b_i;
                    operator_d = core_operator_i;
                    delay_d    = core_delay_i;
                    err_d      = 1'b0;
                    start_d    = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!core_en_i) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (complete) begin
                    res_a_d = fabric_result_a_i;
                    res_b_d = fabric_result_b_i;
                    res_c_d = fabric_result_c_i;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else if (timeout) begin
                    res_a_d = ERR_RESULT;
                    res_b_d = ERR_RESULT;
                    res_c_d = ERR_RESULT;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!core_en_i) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            delay_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            operator_q <= '0;
            res_a_q    <= '0;
            res_b_q    <= '0;
            res_c_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            operator_q <= operator_d;
            res_a_q    <= res_a_d;
            res_b_q    <= res_b_d;
            res_c_q    <= res_c_d;
            done_q     <= done_d;
            err_q      <= err_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
        end
    end

    assign core_result_a_o    = res_a_q;
    assign core_result_b_o    = res_b_q;
    assign core_result_c_o    = res_c_q;
    assign core_done_o        = done_q;
    assign core_err_o         = err_q;
    assign busy_o             = (state_q != IDLE);
    assign fabric_operand_a_o = op_a_q;
    assign fabric_operand_b_o = op_b_q;
    assign fabric_operator_o  = operator_q;
    assign fabric_start_o     = start_q;
    assign fabric_abort_o     = abort_q;

endmodule

// File: tb/tb_flexbex_efpga_bridge.sv
// Self-checking bench for flexbex_efpga_bridge: table of operations plus
// hand-written abort, ignored-strobe and mid-run reset sequences.
module tb_flexbex_efpga_bridge;
    import flexbex_efpga_pkg::*;

    localparam int unsigned TW = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_en_i;
    logic        core_write_strobe_i;
    logic [1:0]  core_operator_i;
    logic [3:0]  core_delay_i;
    logic [31:0] core_operand_a_i;
    logic [31:0] core_operand_b_i;
    logic [31:0] core_result_a_o;
    logic [31:0] core_result_b_o;
    logic [31:0] core_result_c_o;
    logic        core_done_o;
    logic        core_err_o;
    logic        busy_o;
    logic [31:0] fabric_operand_a_o;
    logic [31:0] fabric_operand_b_o;
    logic [1:0]  fabric_operator_o;
    logic        fabric_start_o;
    logic        fabric_abort_o;
    logic [31:0] fabric_result_a_i;
    logic [31:0] fabric_result_b_i;
    logic [31:0] fabric_result_c_i;
    logic        fabric_done_i;

    flexbex_efpga_bridge #(
        .TIMEOUT_W  (TW),
        .ERR_RESULT (32'hDEAD_BEEF)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .core_en_i           (core_en_i),
        .core_write_strobe_i (core_write_strobe_i),
        .core_operator_i     (core_operator_i),
        .core_delay_i        (core_delay_i),
        .core_operand_a_i    (core_operand_a_i),
        .core_operand_b_i    (core_operand_b_i),
        .core_result_a_o     (core_result_a_o),
        .core_result_b_o     (core_result_b_o),
        .core_result_c_o     (core_result_c_o),
        .core_done_o         (core_done_o),
        .core_err_o          (core_err_o),
        .busy_o              (busy_o),
        .fabric_operand_a_o  (fabric_operand_a_o),
        .fabric_operand_b_o  (fabric_operand_b_o),
        .fabric_operator_o   (fabric_operator_o),
        .fabric_start_o      (fabric_start_o),
        .fabric_abort_o      (fabric_abort_o),
        .fabric_result_a_i   (fabric_result_a_i),
        .fabric_result_b_i   (fabric_result_b_i),
        .fabric_result_c_i   (fabric_result_c_i),
        .fabric_done_i       (fabric_done_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  delay;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [31:0] fc;
        int          done_k;   // cycle offset from T of the real fabric done, -1 none
        int          noise_k;  // cycle offset of a done pulse that must be ignored, -1 none
        int          exp_lat;  // offset from T at which core_done_o first reads 1
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
        logic        eerr;
        logic        eabort;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        err;
        logic        abort;
        int          lat;
    } exp_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    exp_t sb [$];

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_a"}, core_result_a_o, 32'd0);
        check({tag, "_res_b"}, core_result_b_o, 32'd0);
        check({tag, "_res_c"}, core_result_c_o, 32'd0);
        check({tag, "_opnd_a"}, fabric_operand_a_o, 32'd0);
        check({tag, "_opnd_b"}, fabric_operand_b_o, 32'd0);
        check({tag, "_operator"}, {30'd0, fabric_operator_o}, 32'd0);
        check_b({tag, "_done"}, core_done_o, 1'b0);
        check_b({tag, "_err"}, core_err_o, 1'b0);
        check_b({tag, "_busy"}, busy_o, 1'b0);
        check_b({tag, "_start"}, fabric_start_o, 1'b0);
        check_b({tag, "_abort"}, fabric_abort_o, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   seen;
        core_operand_a_i    = v.a;
        core_operand_b_i    = v.b;
        core_operator_i     = v.op;
        core_delay_i        = v.delay;
        fabric_result_a_i   = v.fa;
        fabric_result_b_i   = v.fb;
        fabric_result_c_i   = v.fc;
        fabric_done_i       = 1'b0;
        core_en_i           = 1'b1;
        core_write_strobe_i = 1'b1;
        sb.push_back('{v.ea, v.eb, v.ec, v.eerr, v.eabort, v.exp_lat});
        step();
        core_write_strobe_i = 1'b0;
        check_b("start_at_T", fabric_start_o, 1'b1);
        check_b("busy_at_T", busy_o, 1'b1);
        check_b("err_clear_on_launch", core_err_o, 1'b0);
        check("operand_a", fabric_operand_a_o, v.a);
        check("operand_b", fabric_operand_b_o, v.b);
        check("operator", {30'd0, fabric_operator_o}, {30'd0, v.op});
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (core_done_o === 1'b1) begin
                seen          = 1;
                fabric_done_i = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=done required=no_done");
                end else begin
                    e = sb.pop_front();
                    check("done_latency", 32'(k), 32'(e.lat));
                    check("result_a", core_result_a_o, e.a);
                    check("result_b", core_result_b_o, e.b);
                    check("result_c", core_result_c_o, e.c);
                    check_b("err_at_done", core_err_o, e.err);
                    check_b("abort_at_done", fabric_abort_o, e.abort);
                    core_write_strobe_i = 1'b1;
                    for (int h = 0; h < 4; h++) begin
                        step();
                        check_b("hold_done", core_done_o, 1'b1);
                        check_b("hold_no_start", fabric_start_o, 1'b0);
                        check_b("hold_no_abort", fabric_abort_o, 1'b0);
                        check("hold_result_a", core_result_a_o, e.a);
                        check("hold_result_c", core_result_c_o, e.c);
                    end
                    core_write_strobe_i = 1'b0;
                    core_en_i           = 1'b0;
                    step();
                    check_b("release_done", core_done_o, 1'b0);
                    check_b("release_busy", busy_o, 1'b0);
                    check_b("release_err_kept", core_err_o, e.err);
                    check("release_result_a", core_result_a_o, e.a);
                    last_a = e.a;
                end
            end else begin
                if (k > 0) check_b("start_only_at_T", fabric_start_o, 1'b0);
                check_b("no_abort_in_run", fabric_abort_o, 1'b0);
                fabric_done_i = (k == v.done_k) || (k == v.noise_k);
                step();
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_wait actual=no_done required=done_within_40_cycles");
            if (sb.size() != 0) void'(sb.pop_front());
            core_en_i     = 1'b0;
            fabric_done_i = 1'b0;
            step();
            step();
        end
    endtask

    initial begin
        vecs[0] = '{4'd3, 2'd1, 32'd5, 32'd7, 32'h0C, 32'h0C, 32'h0C, -1, -1, 4,
                    32'h0C, 32'h0C, 32'h0C, 1'b0, 1'b0};
        vecs[1] = '{4'd0, 2'd2, 32'd1, 32'd2, 32'hA1, 32'h1234, 32'hC3, 5, 0, 6,
                    32'hA1, 32'h1234, 32'hC3, 1'b0, 1'b0};
        vecs[2] = '{4'd0, 2'd3, 32'd9, 32'd9, 32'h55, 32'h66, 32'h77, -1, -1, 16,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[3] = '{4'd1, 2'd0, 32'hFFFF_0000, 32'h1, 32'h11, 32'h22, 32'h33, -1, 0, 2,
                    32'h11, 32'h22, 32'h33, 1'b0, 1'b0};
        vecs[4] = '{4'd15, 2'd1, 32'h8, 32'h4, 32'hAAAA_5555, 32'h0, 32'h1, -1, 2, 16,
                    32'hAAAA_5555, 32'h0, 32'h1, 1'b0, 1'b0};
        vecs[5] = '{4'd0, 2'd2, 32'h3, 32'h6, 32'h1357, 32'h2468, 32'hFACE, 1, -1, 2,
                    32'h1357, 32'h2468, 32'hFACE, 1'b0, 1'b0};

        last_a              = 32'd0;
        rst_ni              = 1'b0;
        core_en_i           = 1'b0;
        core_write_strobe_i = 1'b0;
        core_operator_i     = 2'd0;
        core_delay_i        = 4'd0;
        core_operand_a_i    = 32'd0;
        core_operand_b_i    = 32'd0;
        fabric_result_a_i   = 32'd0;
        fabric_result_b_i   = 32'd0;
        fabric_result_c_i   = 32'd0;
        fabric_done_i       = 1'b0;
        #2;
        check_all_zero("reset");
        step();
        step();
        rst_ni = 1'b1;
        step();

        core_write_strobe_i = 1'b1;
        core_delay_i        = 4'd2;
        step();
        core_write_strobe_i = 1'b0;
        check_b("strobe_no_en_busy", busy_o, 1'b0);
        check_b("strobe_no_en_start", fabric_start_o, 1'b0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Abort: enable drops two cycles after launch.
        core_delay_i        = 4'd8;
        core_operand_a_i    = 32'h77;
        core_en_i           = 1'b1;
        core_write_strobe_i = 1'b1;
        step();
        core_write_strobe_i = 1'b0;
        check_b("abort_seq_start", fabric_start_o, 1'b1);
        step();
        step();
        core_en_i = 1'b0;
        step();
        check_b("abort_pulse", fabric_abort_o, 1'b1);
        check_b("abort_busy", busy_o, 1'b0);
        check_b("abort_done", core_done_o, 1'b0);
        check("abort_result_kept", core_result_a_o, last_a);
        step();
        check_b("abort_one_cycle", fabric_abort_o, 1'b0);
        begin
            logic done_seen;
            done_seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                done_seen = done_seen | core_done_o;
            end
            check_b("abort_never_done", done_seen, 1'b0);
        end

        // Reset in the middle of a run.
        core_delay_i        = 4'd8;
        core_en_i           = 1'b1;
        core_write_strobe_i = 1'b1;
        step();
        core_write_strobe_i = 1'b0;
        step();
        rst_ni = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        step();
        check_b("midrun_reset_no_abort", fabric_abort_o, 1'b0);
        check_b("midrun_reset_busy", busy_o, 1'b0);
        core_en_i = 1'b0;
        rst_ni    = 1'b1;
        step();
        check_b("post_reset_abort", fabric_abort_o, 1'b0);
        check_b("post_reset_busy", busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
